mux4_rr_arbiter: RTL and testbench
==================================

# mux4_rr_arbiter

Round-robin arbiter and sequencer that shares one `mux4_1` 4:1 selector between four requesters. It samples four request lines and grants exactly one requester at a time. It drives the mux select pair `s1:s0` from a registered grant and bounds each grant's tenure with a hold limit so no requester starves. The block sits directly in front of `mux4_1` and owns its select lines.

## Interface
- `MAX_HOLD`, default 4: maximum consecutive cycles an owner keeps the grant while another requester is waiting; legal range 1..15.
- `clk` in 1: the single clock; all state changes on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req` in 4: request lines; `req[n]` asks for mux input `in`.
- `i0`, `i1`, `i2`, `i3` in 1 each: data inputs, passed to the `mux4_1` instance.
- `gnt` out 4: one-hot grant, or all zero when idle.
- `s0`, `s1` out 1 each: registered mux select; `{s1,s0}` is the granted index.
- `y` out 1: `mux4_1` output for the current select.
- `y_valid` out 1: high iff `gnt != 0`.
- `busy` out 1: high in state GRANT.

## Operation
- State machine has two states, IDLE and GRANT.
- State registers are `owner[1:0]`, `ptr[1:0]` (next-priority index), and `hold_cnt[3:0]`.
- Round-robin pick: the first set bit of `req` scanning `ptr`, `ptr+1`, …, `ptr+3`, all modulo 4.
- IDLE:
  - If `req == 0`, stay in IDLE.
  - Otherwise, on the next edge: `owner` = pick; `gnt` = onehot(owner); `{s1,s0}` = owner; `hold_cnt` = 1; go to GRANT.
- GRANT, evaluated every edge:
  - **Release.** If `req[owner]` is 0, set `ptr` = owner+1.
    - If any other request is set, grant the pick from `owner+1` on the same edge, with no idle bubble, and set `hold_cnt` = 1.
    - Otherwise clear `gnt`, hold `{s1,s0}` at its last value, and go to IDLE.
  - **Preempt.** If `req[owner]` is 1, `hold_cnt == MAX_HOLD`, and any other request is set, rotate to the pick from `owner+1`. Set `ptr` = old owner+1 and `hold_cnt` = 1.
  - **Hold.** Otherwise keep the grant and increment `hold_cnt`, saturating at `MAX_HOLD`. A lone requester holds indefinitely.
- `y` equals the mux output `i{s1,s0}`. It is combinational from the registered select, so it is stable for the full grant cycle.
- Reset values:
  - `gnt` = 0000, `s0` = `s1` = 0, `y_valid` = 0, `busy` = 0.
  - `ptr` = 0, `owner` = 0, `hold_cnt` = 0, state = IDLE.
- Reset mid-grant: `gnt` drops on the edge where `rst` is sampled high. `req` is ignored while `rst` is high.
- Invariant: `gnt` is always one-hot or zero.

## Timing
- Grant latency is 1 cycle: `req` sampled at edge k gives `gnt` from edge k+1.
- Handover latency is 0 idle cycles: the new grant appears on the edge where the release or preempt is sampled.
- The same edge that grants also updates `{s1,s0}`. `y` is valid combinationally after that edge.
- Worst-case wait for a continuously requesting input is 3×`MAX_HOLD` cycles after its request is first sampled.
- All outputs come from registers except `y`.

## Structure
- Shared package `mux_arb_pkg` holds:
  - the state enum {IDLE, GRANT};
  - `NUM_REQ` = 4 and `IDX_W` = 2.
- Sub-module: one instance of the existing `mux4_1` (ports `i0..i3`, `s0`, `s1`, `y`).
- The round-robin pick is a local function inside the arbiter, not a separate module.

## Test plan
- **Single request.** After reset, `req`=0100 for 3 cycles, then 0000.
  - Required: `gnt`=0100 and `{s1,s0}`=10 from the second edge, `y` tracks `i2`.
  - After `req` drops: `gnt`=0000 and state IDLE one edge later.
- **Round-robin order.** Hold `req`=1111 with `MAX_HOLD`=4.
  - Required grant sequence: 0001, 0010, 0100, 1000, 0001, each held exactly 4 cycles.
  - `y_valid` never drops.
- **Release handover.** Owner i1 drops `req[1]` while `req`=1001.
  - Required: the next edge grants 1000 (i3 precedes i0 after owner 1), with no bubble cycle.
- **Lone holder.** `req`=0010 for 20 cycles.
  - Required: `gnt` stays 0010 throughout and `hold_cnt` saturates at 4.
  - Then assert `req[0]`: `gnt`=0001 on the next edge.
- **Reset mid-grant.** While `gnt`=1000, pulse `rst` for 1 cycle with `req`=1111.
  - Required: the edge sampling reset gives `gnt`=0000 and `s1`=`s0`=0.
  - The next edge grants 0001 (`ptr` reset to 0).
- **Mux data check.** In each grant phase of the round-robin scenario, toggle `i0..i3`.
  - Required: `y` equals the granted input and never equals an ungranted input that differs from it.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// rtl/mux_arb_pkg.sv - shared types and sizes for the mux4 round-robin arbiter
package mux_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/mux4_1.sv
// rtl/mux4_1.sv - 4:1 single-bit selector driven by s1:s0
module mux4_1 (
  input  logic i0,
  input  logic i1,
  input  logic i2,
  input  logic i3,
  input  logic s0,
  input  logic s1,
  output logic y
);

  // Pure combinational select of one of four data inputs
  always_comb begin
    y = i0;
    case ({s1, s0})
      2'b00:   y = i0;
      2'b01:   y = i1;
      2'b10:   y = i2;
      default: y = i3;
    endcase
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// rtl/mux4_rr_arbiter.sv - round-robin arbiter owning the select lines of a mux4_1
module mux4_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               i0,
  input  logic               i1,
  input  logic               i2,
  input  logic               i3,
  output logic [NUM_REQ-1:0] gnt,
  output logic               s0,
  output logic               s1,
  output logic               y,
  output logic               y_valid,
  output logic               busy
);

  localparam logic [3:0] HOLD_LIMIT = 4'(MAX_HOLD);

  arb_state_t        state;
  logic [IDX_W-1:0]  owner;
  logic [IDX_W-1:0]  ptr;
  logic [3:0]        hold_cnt;

  logic [IDX_W-1:0]  owner_next_idx;
  logic [IDX_W-1:0]  idle_pick;
  logic [IDX_W-1:0]  rotate_pick;
  logic              others_req;

  // First set request scanning start, start+1, ... modulo NUM_REQ
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                               input logic [IDX_W-1:0]   start);
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] pick;
    pick = start;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = start + IDX_W'(k);
      if (r[idx]) pick = idx;
    end
    return pick;
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    return NUM_REQ'(1) << idx;
  endfunction

  // Candidate picks and competing-request detect for the current cycle
  always_comb begin
    owner_next_idx = owner + IDX_W'(1);
    idle_pick      = rr_pick(req, ptr);
    rotate_pick    = rr_pick(req, owner_next_idx);
    others_req     = (req & ~onehot(owner)) != '0;
  end

  // Arbitration FSM; every output except y is registered here
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      owner    <= '0;
      ptr      <= '0;
      hold_cnt <= '0;
      gnt      <= '0;
      s0       <= 1'b0;
      s1       <= 1'b0;
      y_valid  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req != '0) begin
            owner      <= idle_pick;
            gnt        <= onehot(idle_pick);
            {s1, s0}   <= idle_pick;
            hold_cnt   <= 4'd1;
            y_valid    <= 1'b1;
            busy       <= 1'b1;
            state      <= GRANT;
          end
        end
        GRANT: begin
          if (!req[owner]) begin
            // Owner released: hand over without a bubble, or fall idle
            ptr <= owner_next_idx;
            if (others_req) begin
              owner    <= rotate_pick;
              gnt      <= onehot(rotate_pick);
              {s1, s0} <= rotate_pick;
              hold_cnt <= 4'd1;
            end else begin
              gnt      <= '0;
              y_valid  <= 1'b0;
              busy     <= 1'b0;
              state    <= IDLE;
            end
          end else if (hold_cnt == HOLD_LIMIT && others_req) begin
            // Tenure exhausted while someone waits: force rotation
            ptr      <= owner_next_idx;
            owner    <= rotate_pick;
            gnt      <= onehot(rotate_pick);
            {s1, s0} <= rotate_pick;
            hold_cnt <= 4'd1;
          end else if (hold_cnt < HOLD_LIMIT) begin
            hold_cnt <= hold_cnt + 4'd1;
          end
        end
        default: begin
          state   <= IDLE;
          gnt     <= '0;
          y_valid <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  mux4_1 u_mux (
    .i0 (i0),
    .i1 (i1),
    .i2 (i2),
    .i3 (i3),
    .s0 (s0),
    .s1 (s1),
    .y  (y)
  );

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb/tb_mux4_rr_arbiter.sv - self-checking bench for mux4_rr_arbiter
module tb_mux4_rr_arbiter;

  localparam int MAXH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       i0, i1, i2, i3;
  logic [3:0] gnt;
  logic       s0, s1, y, y_valid, busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: who holds the grant, for how long, and where priority starts
  bit m_active;
  int m_owner;
  int m_ptr;
  int m_tenure;
  int m_sel;

  mux4_rr_arbiter #(.MAX_HOLD(MAXH)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .i0      (i0),
    .i1      (i1),
    .i2      (i2),
    .i3      (i3),
    .gnt     (gnt),
    .s0      (s0),
    .s1      (s1),
    .y       (y),
    .y_valid (y_valid),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
    end
  endtask

  function automatic int first_from(input logic [3:0] r, input int start);
    for (int k = 0; k < 4; k++) begin
      if (r[(start + k) % 4]) return (start + k) % 4;
    end
    return start;
  endfunction

  // Apply the arbitration rules to the inputs seen at this edge
  task automatic model_edge(input logic r_rst, input logic [3:0] r_req);
    logic [3:0] others;
    if (r_rst) begin
      m_active = 0; m_owner = 0; m_ptr = 0; m_tenure = 0; m_sel = 0;
    end else if (!m_active) begin
      if (r_req != 4'b0000) begin
        m_owner  = first_from(r_req, m_ptr);
        m_active = 1;
        m_tenure = 1;
        m_sel    = m_owner;
      end
    end else begin
      others = r_req & ~(4'b0001 << m_owner);
      if (!r_req[m_owner]) begin
        m_ptr = (m_owner + 1) % 4;
        if (others != 4'b0000) begin
          m_owner  = first_from(r_req, m_ptr);
          m_tenure = 1;
          m_sel    = m_owner;
        end else begin
          m_active = 0;
        end
      end else if (m_tenure >= MAXH && others != 4'b0000) begin
        m_ptr    = (m_owner + 1) % 4;
        m_owner  = first_from(r_req, m_ptr);
        m_tenure = 1;
        m_sel    = m_owner;
      end else if (m_tenure < MAXH) begin
        m_tenure = m_tenure + 1;
      end
    end
  endtask

  // One clock: advance model at the edge, compare DUT just after it
  task automatic tick();
    logic [3:0] data;
    logic [3:0] exp_gnt;
    @(posedge clk);
    model_edge(rst, req);
    #1;
    data    = {i3, i2, i1, i0};
    exp_gnt = m_active ? (4'b0001 << m_owner) : 4'b0000;
    chk("gnt", gnt, exp_gnt);
    chk("sel", {2'b00, s1, s0}, 4'(m_sel));
    chk("y_valid", {3'b000, y_valid}, {3'b000, m_active});
    chk("busy", {3'b000, busy}, {3'b000, m_active});
    chk("y", {3'b000, y}, {3'b000, data[m_sel]});
    chk("onehot0", {3'b000, $onehot0(gnt)}, 4'b0001);
  endtask

  task automatic rand_data();
    {i3, i2, i1, i0} = 4'($urandom_range(0, 15));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 4'b0000;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req = 4'b0000;
    {i3, i2, i1, i0} = 4'b0000;

    // Reset state
    tick();
    tick();
    chk("reset_gnt", gnt, 4'b0000);
    chk("reset_sel", {2'b00, s1, s0}, 4'b0000);
    rst = 1'b0;

    // Single request on input 2
    req = 4'b0100;
    for (int c = 0; c < 3; c++) begin
      rand_data();
      tick();
      chk("single_gnt", gnt, 4'b0100);
      chk("single_sel", {2'b00, s1, s0}, 4'b0010);
    end
    req = 4'b0000;
    tick();
    chk("single_release", gnt, 4'b0000);
    chk("single_busy", {3'b000, busy}, 4'b0000);

    // Round-robin order with all requesting
    do_reset();
    req = 4'b1111;
    for (int ph = 0; ph < 5; ph++) begin
      for (int c = 0; c < MAXH; c++) begin
        rand_data();
        tick();
        chk("rr_order", gnt, 4'b0001 << (ph % 4));
        chk("rr_valid", {3'b000, y_valid}, 4'b0001);
      end
    end

    // Release handover: owner 1 drops with 3 and 0 waiting
    do_reset();
    req = 4'b0010;
    tick();
    tick();
    chk("handover_setup", gnt, 4'b0010);
    req = 4'b1001;
    tick();
    chk("handover_gnt", gnt, 4'b1000);

    // Lone holder saturates, then yields to a newcomer
    do_reset();
    req = 4'b0010;
    for (int c = 0; c < 20; c++) begin
      rand_data();
      tick();
      chk("lone_gnt", gnt, 4'b0010);
    end
    chk("lone_hold_cnt", dut.hold_cnt, 4'(MAXH));
    req = 4'b0011;
    tick();
    chk("lone_yield", gnt, 4'b0001);

    // Reset mid-grant while 3 owns the mux
    do_reset();
    req = 4'b1111;
    for (int c = 0; c < 20; c++) begin
      if (gnt == 4'b1000) break;
      tick();
    end
    chk("midgrant_reach", gnt, 4'b1000);
    rst = 1'b1;
    tick();
    chk("midgrant_rst_gnt", gnt, 4'b0000);
    chk("midgrant_rst_sel", {2'b00, s1, s0}, 4'b0000);
    rst = 1'b0;
    tick();
    chk("midgrant_regrant", gnt, 4'b0001);

    // Randomized traffic against the reference
    for (int c = 0; c < 400; c++) begin
      req = 4'($urandom_range(0, 15));
      rst = ($urandom_range(0, 49) == 0);
      rand_data();
      tick();
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
